uart_reg_file: RTL and testbench

UART_REG_FILE -- requirements
Module: uart_reg_file

---
 rtl/uart_reg_file_if.sv | 34 +++
 rtl/uart_reg_file.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_reg_file.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_file_if.sv
// ----------------------------------------------------------------------------
// uart_reg_file_if
// Register-file access bus between the APB front end and uart_reg_file.
//   rf_wr_en  : one-cycle write strobe
//   rf_rd_en  : one-cycle read strobe, the cycle after rf_rdata is sampled
//   rf_addr   : register index
//   rf_wdata  : write data
//   rf_rdata  : combinational read data
// modport master : APB side (drives strobes, address, write data)
// modport slave  : register file side (drives read data)
// ----------------------------------------------------------------------------
interface uart_reg_file_if;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [2:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    modport master (
        output rf_wr_en,
        output rf_rd_en,
        output rf_addr,
        output rf_wdata,
        input  rf_rdata
    );

    modport slave (
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_addr,
        input  rf_wdata,
        output rf_rdata
    );
endinterface

// File: rtl/uart_reg_file.sv
// ----------------------------------------------------------------------------
// uart_reg_file
// UART register file: CTRL, STATS, TX_DATA, RX_DATA and BAUDIV registers,
// plus a 4-byte TX FIFO and a 4-byte RX FIFO.
//   PCLK      : clock, all state changes on rising edge
//   PRESET    : synchronous active-high reset
//   rf        : register bus (slave modport of uart_reg_file_if)
//   tx_data   : TX FIFO head byte
//   tx_valid  : tx_en and TX FIFO not empty
//   tx_ready  : transmitter accepts the head byte
//   rx_data   : received byte
//   rx_valid  : one-cycle strobe qualifying rx_data
//   baud_div  : BAUDIV[15:0]
//   irq       : level interrupt request
// Register map: 0 CTRL, 1 STATS, 2 TX_DATA, 3 RX_DATA, 4 BAUDIV, 5-7 unused.
// ----------------------------------------------------------------------------
module uart_reg_file #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    uart_reg_file_if.slave        rf,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [15:0]           baud_div,
    output logic                  irq
);

    localparam logic [2:0]  DepthCnt  = 3'(FIFO_DEPTH);
    localparam logic [2:0]  AddrCtrl  = 3'd0;
    localparam logic [2:0]  AddrStats = 3'd1;
    localparam logic [2:0]  AddrTxd   = 3'd2;
    localparam logic [2:0]  AddrRxd   = 3'd3;
    localparam logic [2:0]  AddrBaud  = 3'd4;
    localparam logic [15:0] BaudReset = 16'd325;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]  r_ctrl;          // {rx_irq_en, tx_irq_en, rx_en, tx_en}
    logic [15:0] r_baud;
    logic        r_rx_overrun;
    logic        r_tx_overflow;

    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [1:0]  r_tx_wp;
    logic [1:0]  r_tx_rp;
    logic [2:0]  r_tx_cnt;

    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [1:0]  r_rx_wp;
    logic [1:0]  r_rx_rp;
    logic [2:0]  r_rx_cnt;

    // ------------------------------------------------------------------
    // Decode and FIFO control
    // ------------------------------------------------------------------
    logic       w_tx_en;
    logic       w_rx_en;
    logic       w_tx_irq_en;
    logic       w_rx_irq_en;
    logic       w_wr_ctrl;
    logic       w_wr_stats;
    logic       w_wr_txd;
    logic       w_wr_baud;
    logic       w_rd_rxd;
    logic       w_tx_flush;
    logic       w_rx_flush;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_ovf_set;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_ovr_set;
    logic       w_tx_ovf_clr;
    logic       w_rx_ovr_clr;
    logic [2:0] w_tx_cnt_next;
    logic [2:0] w_rx_cnt_next;
    logic       w_unused_wdata;

    assign w_tx_en     = r_ctrl[0];
    assign w_rx_en     = r_ctrl[1];
    assign w_tx_irq_en = r_ctrl[2];
    assign w_rx_irq_en = r_ctrl[3];

    // Upper write-data bits have no destination in any register.
    assign w_unused_wdata = ^rf.rf_wdata[31:16];

    always_comb begin
        w_wr_ctrl  = rf.rf_wr_en && (rf.rf_addr == AddrCtrl);
        w_wr_stats = rf.rf_wr_en && (rf.rf_addr == AddrStats);
        w_wr_txd   = rf.rf_wr_en && (rf.rf_addr == AddrTxd);
        w_wr_baud  = rf.rf_wr_en && (rf.rf_addr == AddrBaud);
        // A concurrent write suppresses the read side effect.
        w_rd_rxd   = rf.rf_rd_en && !rf.rf_wr_en && (rf.rf_addr == AddrRxd);

        w_tx_flush = w_wr_ctrl && rf.rf_wdata[4];
        w_rx_flush = w_wr_ctrl && rf.rf_wdata[5];

        // Full/empty come from pre-edge counts, so a push into a full FIFO
        // is dropped even when a pop happens in the same cycle.
        w_tx_full  = (r_tx_cnt == DepthCnt);
        w_tx_empty = (r_tx_cnt == 3'd0);
        w_rx_full  = (r_rx_cnt == DepthCnt);
        w_rx_empty = (r_rx_cnt == 3'd0);

        w_tx_push    = w_wr_txd && !w_tx_full;
        w_tx_ovf_set = w_wr_txd && w_tx_full;
        w_tx_pop     = w_tx_en && !w_tx_empty && tx_ready;

        w_rx_push    = rx_valid && w_rx_en && !w_rx_full;
        w_rx_ovr_set = rx_valid && w_rx_en && w_rx_full;
        w_rx_pop     = w_rd_rxd && !w_rx_empty;

        w_tx_ovf_clr = w_wr_stats && rf.rf_wdata[5];
        w_rx_ovr_clr = w_wr_stats && rf.rf_wdata[4];

        w_tx_cnt_next = r_tx_cnt + {2'b00, w_tx_push} - {2'b00, w_tx_pop};
        w_rx_cnt_next = r_rx_cnt + {2'b00, w_rx_push} - {2'b00, w_rx_pop};
    end

    // ------------------------------------------------------------------
    // Control registers and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ctrl        <= 4'd0;
            r_baud        <= BaudReset;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= rf.rf_wdata[3:0];
            end
            if (w_wr_baud) begin
                r_baud <= rf.rf_wdata[15:0];
            end
            // Set beats a same-cycle W1C clear.
            r_tx_overflow <= w_tx_ovf_set || (r_tx_overflow && !w_tx_ovf_clr);
            r_rx_overrun  <= w_rx_ovr_set || (r_rx_overrun && !w_rx_ovr_clr);
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (flush overrides push/pop)
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_wp  <= 2'd0;
            r_tx_rp  <= 2'd0;
            r_tx_cnt <= 3'd0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_tx_mem[i] <= 8'd0;
            end
        end else if (w_tx_flush) begin
            r_tx_wp  <= 2'd0;
            r_tx_rp  <= 2'd0;
            r_tx_cnt <= 3'd0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= rf.rf_wdata[7:0];
                r_tx_wp           <= r_tx_wp + 2'd1;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + 2'd1;
            end
            r_tx_cnt <= w_tx_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (flush overrides push/pop)
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_wp  <= 2'd0;
            r_rx_rp  <= 2'd0;
            r_rx_cnt <= 3'd0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_rx_mem[i] <= 8'd0;
            end
        end else if (w_rx_flush) begin
            r_rx_wp  <= 2'd0;
            r_rx_rp  <= 2'd0;
            r_rx_cnt <= 3'd0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= rx_data;
                r_rx_wp           <= r_rx_wp + 2'd1;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + 2'd1;
            end
            r_rx_cnt <= w_rx_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    logic [31:0] w_stats;

    always_comb begin
        w_stats        = 32'd0;
        w_stats[0]     = w_tx_empty;
        w_stats[1]     = w_tx_full;
        w_stats[2]     = !w_rx_empty;
        w_stats[3]     = w_rx_full;
        w_stats[4]     = r_rx_overrun;
        w_stats[5]     = r_tx_overflow;
        w_stats[10:8]  = r_tx_cnt;
        w_stats[14:12] = r_rx_cnt;
    end

    always_comb begin
        rf.rf_rdata = 32'd0;
        case (rf.rf_addr)
            AddrCtrl:  rf.rf_rdata = {28'd0, r_ctrl};
            AddrStats: rf.rf_rdata = w_stats;
            AddrRxd:   rf.rf_rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
            AddrBaud:  rf.rf_rdata = {16'd0, r_baud};
            default:   rf.rf_rdata = 32'd0;
        endcase
    end

    assign tx_data  = r_tx_mem[r_tx_rp];
    assign tx_valid = w_tx_en && !w_tx_empty;
    assign baud_div = r_baud;
    assign irq      = (w_tx_irq_en && w_tx_empty) || (w_rx_irq_en && !w_rx_empty)
                      || r_rx_overrun || r_tx_overflow;

endmodule

// File: tb/tb_uart_reg_file.sv
// ----------------------------------------------------------------------------
// tb_uart_reg_file
// Directed self-checking bench for uart_reg_file. Inputs change on the
// falling edge of PCLK; outputs are sampled 1 ns after a falling edge.
// ----------------------------------------------------------------------------
module tb_uart_reg_file;

    logic        PCLK;
    logic        PRESET;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] baud_div;
    logic        irq;

    int n_compared;
    int n_mismatched;

    uart_reg_file_if bus ();

    uart_reg_file #(
        .FIFO_DEPTH (4)
    ) u_dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .rf       (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .baud_div (baud_div),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        bus.rf_addr  = a;
        bus.rf_wdata = d;
        bus.rf_wr_en = 1'b1;
        @(negedge PCLK);
        bus.rf_wr_en = 1'b0;
    endtask

    // Sample rf_rdata, then strobe rf_rd_en for one cycle.
    task automatic reg_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.rf_addr = a;
        #1;
        check_eq(tag, bus.rf_rdata, exp);
        @(negedge PCLK);
        bus.rf_rd_en = 1'b1;
        @(negedge PCLK);
        bus.rf_rd_en = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge PCLK);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_tx [4];
        logic [7:0] exp_rx [4];
        n_compared   = 0;
        n_mismatched = 0;
        PRESET       = 1'b1;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'd0;
        bus.rf_wr_en = 1'b0;
        bus.rf_rd_en = 1'b0;
        bus.rf_addr  = 3'd0;
        bus.rf_wdata = 32'd0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        // Reset state
        #1;
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_baud_div", {16'd0, baud_div}, 32'd325);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        reg_read("rst_stats", 3'd1, 32'h0000_0001);
        reg_read("rst_baudiv", 3'd4, 32'h0000_0145);
        reg_read("rst_ctrl", 3'd0, 32'h0000_0000);

        // TX fill with overflow
        reg_write(3'd0, 32'h1);
        reg_write(3'd2, 32'h11);
        reg_write(3'd2, 32'h22);
        reg_write(3'd2, 32'h33);
        reg_write(3'd2, 32'h44);
        reg_write(3'd2, 32'h55);
        #1;
        check_eq("txfull_irq", {31'd0, irq}, 32'd1);
        check_eq("txfull_tx_data", {24'd0, tx_data}, 32'h11);
        check_eq("txfull_tx_valid", {31'd0, tx_valid}, 32'd1);
        reg_read("txfull_stats", 3'd1, 32'h0000_0422);

        // Drain TX
        exp_tx[0] = 8'h11;
        exp_tx[1] = 8'h22;
        exp_tx[2] = 8'h33;
        exp_tx[3] = 8'h44;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("drain_tx_data", {24'd0, tx_data}, {24'd0, exp_tx[i]});
            check_eq("drain_tx_valid", {31'd0, tx_valid}, 32'd1);
            @(negedge PCLK);
        end
        #1;
        check_eq("drained_tx_valid", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        reg_read("ovf_still_set", 3'd1, 32'h0000_0021);
        reg_write(3'd1, 32'h20);
        reg_read("ovf_cleared", 3'd1, 32'h0000_0001);
        #1;
        check_eq("ovf_cleared_irq", {31'd0, irq}, 32'd0);

        // RX fill with overrun, then read out
        reg_write(3'd0, 32'h2);
        for (int i = 0; i < 5; i++) begin
            rx_strobe(8'hA0 + 8'(i));
        end
        #1;
        check_eq("rxovr_irq", {31'd0, irq}, 32'd1);
        reg_read("rxovr_stats", 3'd1, 32'h0000_401D);
        for (int i = 0; i < 4; i++) begin
            reg_read("rx_pop_data", 3'd3, 32'hA0 + 32'(i));
        end
        reg_read("rx_empty_data", 3'd3, 32'h0);
        reg_read("rx_empty_stats", 3'd1, 32'h0000_0011);
        reg_write(3'd1, 32'h10);
        reg_read("rxovr_cleared", 3'd1, 32'h0000_0001);

        // Full RX with simultaneous push and pop: push dropped
        for (int i = 0; i < 4; i++) begin
            rx_strobe(8'hB0 + 8'(i));
        end
        bus.rf_addr  = 3'd3;
        bus.rf_rd_en = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'hCC;
        @(negedge PCLK);
        bus.rf_rd_en = 1'b0;
        rx_valid     = 1'b0;
        reg_read("pushpop_stats", 3'd1, 32'h0000_3015);
        rx_strobe(8'hDD);
        // Overrun set and W1C clear in the same cycle: set wins
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        reg_write(3'd1, 32'h10);
        rx_valid = 1'b0;
        reg_read("setwins_stats", 3'd1, 32'h0000_401D);
        exp_rx[0] = 8'hB1;
        exp_rx[1] = 8'hB2;
        exp_rx[2] = 8'hB3;
        exp_rx[3] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            reg_read("pushpop_data", 3'd3, {24'd0, exp_rx[i]});
        end
        reg_write(3'd1, 32'h10);

        // RX flush
        rx_strobe(8'h5A);
        rx_strobe(8'h5B);
        reg_write(3'd0, 32'h22);
        reg_read("rxflush_stats", 3'd1, 32'h0000_0001);
        reg_read("rxflush_ctrl", 3'd0, 32'h0000_0002);

        // TX stall with tx_en low, then flush via CTRL 0x13
        reg_write(3'd0, 32'h0);
        tx_ready = 1'b1;
        reg_write(3'd2, 32'h77);
        reg_write(3'd2, 32'h88);
        #1;
        check_eq("stall_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("stall_tx_data", {24'd0, tx_data}, 32'h77);
        reg_read("stall_stats", 3'd1, 32'h0000_0200);
        tx_ready = 1'b0;
        reg_write(3'd0, 32'h13);
        reg_read("txflush_stats", 3'd1, 32'h0000_0001);
        reg_read("txflush_ctrl", 3'd0, 32'h0000_0003);

        // BAUDIV, TX_DATA and unused addresses
        reg_write(3'd4, 32'hABCD_1234);
        reg_read("baudiv_rw", 3'd4, 32'h0000_1234);
        #1;
        check_eq("baud_div_out", {16'd0, baud_div}, 32'h1234);
        reg_write(3'd2, 32'h66);
        reg_read("txdata_reads0", 3'd2, 32'h0);
        reg_write(3'd5, 32'hFFFF_FFFF);
        reg_read("addr5_reads0", 3'd5, 32'h0);
        reg_read("addr7_reads0", 3'd7, 32'h0);
        reg_read("post_unused_ctrl", 3'd0, 32'h0000_0003);

        // Reset mid-operation with a concurrent write
        rx_strobe(8'h42);
        PRESET       = 1'b1;
        bus.rf_addr  = 3'd4;
        bus.rf_wdata = 32'h5555;
        bus.rf_wr_en = 1'b1;
        rx_valid     = 1'b1;
        @(negedge PCLK);
        PRESET       = 1'b0;
        bus.rf_wr_en = 1'b0;
        rx_valid     = 1'b0;
        #1;
        check_eq("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("midrst_irq", {31'd0, irq}, 32'd0);
        check_eq("midrst_baud_div", {16'd0, baud_div}, 32'd325);
        reg_read("midrst_stats", 3'd1, 32'h0000_0001);
        reg_read("midrst_ctrl", 3'd0, 32'h0000_0000);
        reg_read("midrst_rxdata", 3'd3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
